eth_tx_axis_arb: RTL and testbench

Packet-granular round-robin arbiter that shares one Ethernet TX AXI-Stream path between NUM_SRC frame generators, for example test generators and the ARP/UDP builders.
- Grants one source for a whole frame, from first beat to tlast. Routes that source's tdata, tkeep, tvalid, tlast and tx_size to the MAC-side port, and returns tready only to the winner.
- Sits between the frame sources and the eth_ctrl TX framer.

---
 rtl/eth_axis_pkg.sv | 19 +
 rtl/eth_tx_axis_arb_rr_pick.sv | 25 ++
 rtl/eth_tx_axis_arb.sv | 120 ++++++++++++
 tb/tb_eth_tx_axis_arb.sv | 488 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_axis_pkg.sv
// Shared definitions for the Ethernet AXI-Stream TX/RX plumbing.
package eth_axis_pkg;

  localparam int DEF_AXIS_DATA_WIDTH = 64;
  localparam int DEF_LEN_WIDTH       = 16;

  // Arbiter FSM states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_XFER  = 2'd2
  } arb_state_t;

  // Addressing constants used by the frame sources
  localparam logic [47:0] ETH_BCAST_MAC = 48'hFFFF_FFFF_FFFF;
  localparam logic [15:0] ETH_TYPE_IPV4 = 16'h0800;
  localparam logic [15:0] ETH_TYPE_ARP  = 16'h0806;

endpackage

// File: rtl/eth_tx_axis_arb_rr_pick.sv
// Combinational round-robin priority search: first set bit of req above
// 'last', wrapping at N (not at 2^IW).
module rr_pick #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic          found,
  output logic [IW-1:0] idx
);

  // Walk from lowest priority (last itself) toward highest so the nearest hit wins
  always_comb begin
    int unsigned c;
    c     = 0;
    found = |req;
    idx   = last;
    for (int unsigned k = N; k >= 1; k--) begin
      c = (32'(last) + k) % N;
      if (req[IW'(c)]) idx = IW'(c);
    end
  end

endmodule

// File: rtl/eth_tx_axis_arb.sv
// Packet-granular round-robin arbiter sharing one Ethernet TX AXI-Stream path.
module eth_tx_axis_arb
  import eth_axis_pkg::*;
#(
  parameter int NUM_SRC         = 2,
  parameter int AXIS_DATA_WIDTH = DEF_AXIS_DATA_WIDTH,
  parameter int LEN_WIDTH       = DEF_LEN_WIDTH,
  parameter int IDLE_TIMEOUT    = 1024
) (
  input  logic                              clk,
  input  logic                              rstn,
  input  logic [NUM_SRC-1:0]                s_req,
  input  logic [NUM_SRC*LEN_WIDTH-1:0]      s_tx_size,
  input  logic [NUM_SRC*AXIS_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_SRC*AXIS_DATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic [NUM_SRC-1:0]                s_axis_tvalid,
  input  logic [NUM_SRC-1:0]                s_axis_tlast,
  output logic [NUM_SRC-1:0]                s_axis_tready,
  output logic [LEN_WIDTH-1:0]              m_tx_size,
  output logic [AXIS_DATA_WIDTH-1:0]        m_axis_tdata,
  output logic [AXIS_DATA_WIDTH/8-1:0]      m_axis_tkeep,
  output logic                              m_axis_tvalid,
  output logic                              m_axis_tlast,
  input  logic                              m_axis_tready,
  output logic [$clog2(NUM_SRC)-1:0]        grant_idx,
  output logic                              busy,
  output logic                              timeout_err
);

  localparam int KW  = AXIS_DATA_WIDTH / 8;
  localparam int IW  = $clog2(NUM_SRC);
  localparam int CW  = $clog2(IDLE_TIMEOUT);
  localparam int DBW = $clog2(NUM_SRC * AXIS_DATA_WIDTH);
  localparam int KBW = $clog2(NUM_SRC * KW);
  localparam int LBW = $clog2(NUM_SRC * LEN_WIDTH);

  arb_state_t     state, state_next;
  logic [CW-1:0]  stall_cnt;
  logic [NUM_SRC-1:0] req;
  logic           pick_found;
  logic [IW-1:0]  pick_idx;
  logic           accept;
  logic           stall_hit;
  logic [DBW-1:0] dbase;
  logic [KBW-1:0] kbase;
  logic [LBW-1:0] lbase;

  // Sources that hold tvalid low until tready must raise s_req instead
  assign req   = s_req | s_axis_tvalid;
  assign dbase = DBW'(int'(grant_idx) * AXIS_DATA_WIDTH);
  assign kbase = KBW'(int'(grant_idx) * KW);
  assign lbase = LBW'(int'(pick_idx) * LEN_WIDTH);

  rr_pick #(
    .N  (NUM_SRC),
    .IW (IW)
  ) u_pick (
    .req   (req),
    .last  (grant_idx),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rstn) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Grant bookkeeping: winner index, latched frame size, stall counter
  always_ff @(posedge clk) begin
    if (!rstn) begin
      grant_idx <= IW'(NUM_SRC - 1);
      m_tx_size <= '0;
      stall_cnt <= '0;
    end else begin
      if (state == ST_IDLE && pick_found) begin
        grant_idx <= pick_idx;
        m_tx_size <= s_tx_size[lbase +: LEN_WIDTH];
      end
      if (state != ST_XFER || accept || stall_hit) stall_cnt <= '0;
      else                                         stall_cnt <= stall_cnt + CW'(1);
    end
  end

  // Next-state and stream routing; only the granted source is connected, and
  // the routing is cut in the same cycle the stall limit forces a release
  always_comb begin
    state_next    = state;
    accept        = 1'b0;
    stall_hit     = 1'b0;
    m_axis_tdata  = '0;
    m_axis_tkeep  = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    s_axis_tready = '0;
    case (state)
      ST_IDLE:  if (pick_found) state_next = ST_GRANT;
      ST_GRANT: state_next = ST_XFER;
      ST_XFER: begin
        stall_hit = (stall_cnt == CW'(IDLE_TIMEOUT - 1));
        if (stall_hit) begin
          state_next = ST_IDLE;
        end else begin
          m_axis_tdata             = s_axis_tdata[dbase +: AXIS_DATA_WIDTH];
          m_axis_tkeep             = s_axis_tkeep[kbase +: KW];
          m_axis_tvalid            = s_axis_tvalid[grant_idx];
          m_axis_tlast             = s_axis_tlast[grant_idx];
          s_axis_tready[grant_idx] = m_axis_tready;
          accept = s_axis_tvalid[grant_idx] & m_axis_tready;
          if (accept && s_axis_tlast[grant_idx]) state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
    busy        = (state != ST_IDLE);
    timeout_err = stall_hit;
  end

endmodule

// File: tb/tb_eth_tx_axis_arb.sv
// Self-checking bench for eth_tx_axis_arb: queue-based source/sink model with
// a frame-level round-robin reference.
module tb_eth_tx_axis_arb;

  localparam int N  = 2;
  localparam int W  = 64;
  localparam int K  = 8;
  localparam int L  = 16;
  localparam int TO = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rstn;
  logic [N-1:0]   s_req, s_tvalid, s_tlast, s_tready;
  logic [N*L-1:0] s_tx_size;
  logic [N*W-1:0] s_tdata;
  logic [N*K-1:0] s_tkeep;
  logic [L-1:0]   m_tx_size;
  logic [W-1:0]   m_tdata;
  logic [K-1:0]   m_tkeep;
  logic           m_tvalid, m_tlast, m_tready;
  logic [0:0]     grant_idx;
  logic           busy, terr;

  logic [2:0]     t3_req, t3_tvalid, t3_tlast, t3_tready;
  logic [3*L-1:0] t3_tx_size;
  logic [3*W-1:0] t3_tdata;
  logic [3*K-1:0] t3_tkeep;
  logic [L-1:0]   t3_m_tx_size;
  logic [W-1:0]   t3_m_tdata;
  logic [K-1:0]   t3_m_tkeep;
  logic           t3_m_tvalid, t3_m_tlast, t3_m_tready;
  logic [1:0]     t3_gidx;
  logic           t3_busy, t3_terr;

  eth_tx_axis_arb #(
    .NUM_SRC(N), .AXIS_DATA_WIDTH(W), .LEN_WIDTH(L), .IDLE_TIMEOUT(TO)
  ) dut (
    .clk(clk), .rstn(rstn), .s_req(s_req), .s_tx_size(s_tx_size),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
    .s_axis_tlast(s_tlast), .s_axis_tready(s_tready), .m_tx_size(m_tx_size),
    .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tvalid(m_tvalid),
    .m_axis_tlast(m_tlast), .m_axis_tready(m_tready), .grant_idx(grant_idx),
    .busy(busy), .timeout_err(terr)
  );

  eth_tx_axis_arb #(
    .NUM_SRC(3), .AXIS_DATA_WIDTH(W), .LEN_WIDTH(L), .IDLE_TIMEOUT(1024)
  ) dut3 (
    .clk(clk), .rstn(rstn), .s_req(t3_req), .s_tx_size(t3_tx_size),
    .s_axis_tdata(t3_tdata), .s_axis_tkeep(t3_tkeep), .s_axis_tvalid(t3_tvalid),
    .s_axis_tlast(t3_tlast), .s_axis_tready(t3_tready), .m_tx_size(t3_m_tx_size),
    .m_axis_tdata(t3_m_tdata), .m_axis_tkeep(t3_m_tkeep), .m_axis_tvalid(t3_m_tvalid),
    .m_axis_tlast(t3_m_tlast), .m_axis_tready(t3_m_tready), .grant_idx(t3_gidx),
    .busy(t3_busy), .timeout_err(t3_terr)
  );

  int tests_run = 0;
  int tests_failed = 0;

  // Source model: per-source queues of pending beats and frame sizes
  logic [W-1:0] dq[N][$];
  logic [K-1:0] kq[N][$];
  bit           lq[N][$];
  int           szq[N][$];
  int vprob[N];
  int vcap[N];
  int sent[N];
  int nbeats[N];
  int rmode = 0;
  int rprob = 100;
  int cyc = 0;

  // Reference model: frame-level round-robin owner
  int last_g = N - 1;
  bit in_frame = 0;
  int own = 0;
  int order[$];

  // Snapshot taken at the falling edge of each cycle
  logic          sb_busy, sb_terr, sb_mvalid, sb_macc, sb_mready;
  logic [0:0]    sb_gidx;
  logic [N-1:0]  sb_tready;
  logic [L-1:0]  sb_txsize;
  logic [93:0]   sb_outs;

  function automatic int rr_next(input int last, input bit [N-1:0] mask);
    for (int k = 1; k <= N; k++)
      if (mask[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  task automatic push_frame(input int src, input int beats, input bit full);
    int r;
    r = full ? 0 : $urandom_range(7);
    for (int b = 0; b < beats; b++) begin
      dq[src].push_back({$urandom, $urandom});
      kq[src].push_back(b == beats - 1 ? 8'(8'hFF >> r) : 8'hFF);
      lq[src].push_back(b == beats - 1);
    end
    szq[src].push_back((beats - 1) * 8 + 8 - r);
  endtask

  task automatic clear_queues();
    for (int i = 0; i < N; i++) begin
      dq[i].delete(); kq[i].delete(); lq[i].delete(); szq[i].delete();
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      bit have;
      have = dq[i].size() != 0;
      s_req[i]    = have;
      s_tvalid[i] = have && (sent[i] < vcap[i]) && ($urandom_range(99) < vprob[i]);
      s_tdata[i*W +: W]   = have ? dq[i][0] : '0;
      s_tkeep[i*K +: K]   = have ? kq[i][0] : '0;
      s_tlast[i]          = have ? lq[i][0] : 1'b0;
      s_tx_size[i*L +: L] = have ? L'(szq[i][0]) : '0;
    end
    case (rmode)
      1:       m_tready = (cyc % 2 == 0);
      2:       m_tready = ($urandom_range(99) < rprob);
      default: m_tready = 1'b1;
    endcase
  endtask

  // One clock: drive sources, check the sink side at negedge, then advance sources
  task automatic cycle();
    logic [N-1:0] acc_src;
    bit [N-1:0]   pend;
    logic [N-1:0] exp_rdy;
    drive();
    @(negedge clk);
    sb_busy = busy; sb_terr = terr; sb_mvalid = m_tvalid; sb_mready = m_tready;
    sb_macc = m_tvalid & m_tready; sb_gidx = grant_idx; sb_tready = s_tready;
    sb_txsize = m_tx_size;
    sb_outs = {m_tvalid, m_tlast, m_tdata, m_tkeep, m_tx_size, s_tready, busy, terr};
    acc_src = s_tvalid & s_tready;
    for (int i = 0; i < N; i++) pend[i] = dq[i].size() != 0;
    if (sb_macc === 1'b1) begin
      if (!in_frame) begin
        own = rr_next(last_g, pend);
        in_frame = 1;
        order.push_back(own);
      end
      tests_run++;
      if (own < 0 || dq[own].size() == 0) begin
        tests_failed++;
        $display("FAIL spurious_beat: got beat data=%h with no pending frame for owner %0d", m_tdata, own);
        in_frame = 0;
      end else begin
        if ({m_tdata, m_tkeep, m_tlast} !== {dq[own][0], kq[own][0], lq[own][0]}) begin
          tests_failed++;
          $display("FAIL beat_data: got %h/%h/%b, expected %h/%h/%b (src %0d)",
                   m_tdata, m_tkeep, m_tlast, dq[own][0], kq[own][0], lq[own][0], own);
        end
        tests_run++;
        if (m_tx_size !== L'(szq[own][0])) begin
          tests_failed++;
          $display("FAIL tx_size: got %0d, expected %0d", m_tx_size, szq[own][0]);
        end
        exp_rdy = '0;
        exp_rdy[own] = 1'b1;
        tests_run++;
        if (s_tready !== exp_rdy || grant_idx !== 1'(own)) begin
          tests_failed++;
          $display("FAIL ready_route: got tready=%b grant=%0d, expected tready=%b grant=%0d",
                   s_tready, grant_idx, exp_rdy, own);
        end
        nbeats[own]++;
        if (m_tlast) begin
          in_frame = 0;
          last_g = own;
        end
      end
    end
    if (sb_terr === 1'b1) begin
      in_frame = 0;
      last_g = own;
    end
    if (!rstn) begin
      in_frame = 0;
      last_g = N - 1;
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (acc_src[i] === 1'b1 && dq[i].size() != 0) begin
        if (lq[i][0]) void'(szq[i].pop_front());
        void'(dq[i].pop_front()); void'(kq[i].pop_front()); void'(lq[i].pop_front());
        sent[i]++;
      end
    end
    cyc++;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    cycle();
    rstn = 1'b1;
  endtask

  task automatic run_until_empty(input string name, input int budget);
    int n;
    n = 0;
    while ((dq[0].size() != 0 || dq[1].size() != 0) && n < budget) begin
      cycle();
      n++;
    end
    tests_run++;
    if (dq[0].size() != 0 || dq[1].size() != 0) begin
      tests_failed++;
      $display("FAIL %s_drain: %0d/%0d beats left after %0d cycles, expected 0/0",
               name, dq[0].size(), dq[1].size(), budget);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    cycle();
    cycle();
    tests_run++;
    if (sb_outs !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got %h, expected 0", sb_outs);
    end
    tests_run++;
    if (sb_gidx !== 1'b1 || t3_gidx !== 2'd2) begin
      tests_failed++;
      $display("FAIL reset_grant_idx: got %0d/%0d, expected 1/2", sb_gidx, t3_gidx);
    end
    rstn = 1'b1;
  endtask

  task automatic test_single();
    int base;
    base = nbeats[0];
    push_frame(0, 128, 1);
    cycle();
    tests_run++;
    if (sb_busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_busy_c0: got %b, expected 0", sb_busy);
    end
    cycle();
    tests_run++;
    if ({sb_busy, sb_gidx} !== 2'b10) begin
      tests_failed++;
      $display("FAIL single_grant_c1: got busy=%b grant=%0d, expected busy=1 grant=0", sb_busy, sb_gidx);
    end
    cycle();
    tests_run++;
    if (sb_mvalid !== 1'b1 || sb_txsize !== 16'd1024) begin
      tests_failed++;
      $display("FAIL single_first_beat: got valid=%b size=%0d, expected valid=1 size=1024", sb_mvalid, sb_txsize);
    end
    run_until_empty("single", 300);
    cycle();
    tests_run++;
    if (sb_busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_busy_after_tlast: got %b, expected 0", sb_busy);
    end
    tests_run++;
    if (nbeats[0] - base != 128) begin
      tests_failed++;
      $display("FAIL single_beat_count: got %0d, expected 128", nbeats[0] - base);
    end
  endtask

  task automatic test_alternate();
    do_reset();
    order.delete();
    for (int f = 0; f < 4; f++) begin
      push_frame(0, 8, 1);
      push_frame(1, 8, 1);
    end
    run_until_empty("alternate", 400);
    tests_run++;
    if (order.size() != 8) begin
      tests_failed++;
      $display("FAIL alternate_frames: got %0d frames, expected 8", order.size());
    end
    for (int k = 0; k < order.size(); k++) begin
      tests_run++;
      if (order[k] != k % 2) begin
        tests_failed++;
        $display("FAIL alternate_order[%0d]: got src %0d, expected %0d", k, order[k], k % 2);
      end
    end
  endtask

  task automatic test_throttle();
    int base, n;
    logic [N-1:0] exp_rdy;
    base = nbeats[1];
    rmode = 1;
    push_frame(1, 8, 0);
    n = 0;
    while (dq[1].size() != 0 && n < 100) begin
      cycle();
      exp_rdy = sb_mvalid ? {sb_mready, 1'b0} : 2'b00;
      tests_run++;
      if (sb_tready !== exp_rdy) begin
        tests_failed++;
        $display("FAIL throttle_ready cyc %0d: got %b, expected %b", cyc, sb_tready, exp_rdy);
      end
      n++;
    end
    tests_run++;
    if (nbeats[1] - base != 8) begin
      tests_failed++;
      $display("FAIL throttle_beats: got %0d, expected 8", nbeats[1] - base);
    end
    rmode = 0;
  endtask

  task automatic test_timeout();
    int since, n, b0, b1;
    do_reset();
    b0 = nbeats[0];
    b1 = nbeats[1];
    vcap[0] = sent[0] + 3;
    push_frame(0, 8, 1);
    push_frame(1, 4, 0);
    since = 0;
    n = 0;
    do begin
      cycle();
      if (sb_macc === 1'b1) since = 0;
      else                  since++;
      n++;
    end while (sb_terr !== 1'b1 && n < 200);
    tests_run++;
    if (sb_terr !== 1'b1 || since != TO) begin
      tests_failed++;
      $display("FAIL timeout_latency: got pulse=%b after %0d idle cycles, expected pulse=1 after %0d", sb_terr, since, TO);
    end
    tests_run++;
    if (nbeats[0] - b0 != 3) begin
      tests_failed++;
      $display("FAIL timeout_beats: got %0d, expected 3", nbeats[0] - b0);
    end
    dq[0].delete(); kq[0].delete(); lq[0].delete(); szq[0].delete();
    vcap[0] = 32'h7fff_ffff;
    cycle();
    tests_run++;
    if (sb_busy !== 1'b0 || sb_terr !== 1'b0) begin
      tests_failed++;
      $display("FAIL timeout_release: got busy=%b err=%b, expected 0/0", sb_busy, sb_terr);
    end
    cycle();
    tests_run++;
    if ({sb_busy, sb_gidx} !== 2'b11) begin
      tests_failed++;
      $display("FAIL timeout_regrant: got busy=%b grant=%0d, expected busy=1 grant=1", sb_busy, sb_gidx);
    end
    run_until_empty("timeout", 100);
    tests_run++;
    if (nbeats[1] - b1 != 4) begin
      tests_failed++;
      $display("FAIL timeout_src1_beats: got %0d, expected 4", nbeats[1] - b1);
    end
  endtask

  task automatic test_reset_mid();
    int base, n;
    do_reset();
    base = nbeats[0];
    push_frame(0, 10, 1);
    push_frame(1, 10, 1);
    n = 0;
    while (nbeats[0] - base < 4 && n < 50) begin
      cycle();
      n++;
    end
    rstn = 1'b0;
    cycle();
    rstn = 1'b1;
    clear_queues();
    order.delete();
    push_frame(0, 3, 0);
    push_frame(1, 3, 0);
    cycle();
    tests_run++;
    if (sb_outs !== '0 || sb_gidx !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_mid_outputs: got outs=%h grant=%0d, expected 0 grant=1", sb_outs, sb_gidx);
    end
    run_until_empty("reset_mid", 100);
    tests_run++;
    if (order.size() != 2 || order[0] != 0) begin
      tests_failed++;
      $display("FAIL reset_mid_first_grant: got %0d frames first=%0d, expected 2 frames first=0",
               order.size(), order.size() ? order[0] : -1);
    end
  endtask

  task automatic test_random();
    int frames;
    vprob[0] = 85; vprob[1] = 85;
    rmode = 2; rprob = 75;
    order.delete();
    frames = 0;
    for (int r = 0; r < 6; r++) begin
      int nf;
      nf = $urandom_range(1, 3);
      for (int f = 0; f < nf; f++) begin
        push_frame($urandom_range(1), $urandom_range(1, 6), 0);
        frames++;
      end
      run_until_empty("random", 2000);
    end
    tests_run++;
    if (order.size() != frames) begin
      tests_failed++;
      $display("FAIL random_frames: got %0d, expected %0d", order.size(), frames);
    end
    vprob[0] = 100; vprob[1] = 100;
    rmode = 0;
  endtask

  task automatic test_three();
    int rem0, rem2, k, n, exp_src;
    rem0 = 3; rem2 = 3; k = 0; n = 0;
    while ((rem0 > 0 || rem2 > 0) && n < 100) begin
      t3_req      = {rem2 > 0, 1'b0, rem0 > 0};
      t3_tvalid   = t3_req;
      t3_tlast    = 3'b111;
      t3_tdata    = {64'd2, 64'd1, 64'd0};
      t3_tkeep    = '1;
      t3_tx_size  = {16'd8, 16'd8, 16'd8};
      t3_m_tready = 1'b1;
      @(negedge clk);
      if (t3_m_tvalid === 1'b1) begin
        exp_src = (k % 2 == 0) ? 0 : 2;
        tests_run++;
        if (t3_m_tdata !== 64'(exp_src) || t3_gidx !== 2'(exp_src) || t3_tready[1] !== 1'b0) begin
          tests_failed++;
          $display("FAIL three_order[%0d]: got data=%0d grant=%0d tready=%b, expected src %0d",
                   k, t3_m_tdata, t3_gidx, t3_tready, exp_src);
        end
        if (t3_tready[0] === 1'b1) rem0--;
        if (t3_tready[2] === 1'b1) rem2--;
        k++;
      end
      @(posedge clk);
      #1;
      n++;
    end
    t3_req = '0; t3_tvalid = '0; t3_tlast = '0;
    tests_run++;
    if (k != 6) begin
      tests_failed++;
      $display("FAIL three_frames: got %0d, expected 6", k);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0;
    s_req = '0; s_tvalid = '0; s_tlast = '0; s_tdata = '0; s_tkeep = '0; s_tx_size = '0;
    m_tready = 1'b0;
    t3_req = '0; t3_tvalid = '0; t3_tlast = '0; t3_tdata = '0; t3_tkeep = '0;
    t3_tx_size = '0; t3_m_tready = 1'b0;
    for (int i = 0; i < N; i++) begin
      vprob[i] = 100; vcap[i] = 32'h7fff_ffff; sent[i] = 0; nbeats[i] = 0;
    end
    test_reset();
    test_single();
    test_alternate();
    test_throttle();
    test_timeout();
    test_reset_mid();
    test_random();
    test_three();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
